// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: mdOp encodings and default latencies.
// Used by the decoder, the stall unit's Tuse/Tnew logic and e_mdu.
package mdu_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   function automatic logic is_mul(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result generator for mult/multu/div/divu.
// div_zero flags a divide op with a zero divisor.
module md_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div_zero
);

   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               b_zero;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;
   logic [31:0]        sdvs;
   logic [31:0]        udvs;
   logic [31:0]        mq;
   logic [31:0]        mr;
   logic [31:0]        sq;
   logic [31:0]        sr;
   logic [31:0]        uq;
   logic [31:0]        ur;

   always_comb begin
      sa     = {{32{a[31]}}, a};
      sb     = {{32{b[31]}}, b};
      prod_s = sa * sb;
      prod_u = {32'd0, a} * {32'd0, b};
      b_zero = (b == 32'd0);
      abs_a  = a[31] ? (32'd0 - a) : a;
      abs_b  = b[31] ? (32'd0 - b) : b;
      // Divisor forced to 1 on zero so the dividers never see x/0
      sdvs   = b_zero ? 32'd1 : abs_b;
      udvs   = b_zero ? 32'd1 : b;
      mq     = abs_a / sdvs;
      mr     = abs_a % sdvs;
      uq     = a / udvs;
      ur     = a % udvs;
      // 0x80000000 / -1 falls out as 0x80000000 with this magnitude scheme
      sq     = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
      sr     = a[31] ? (32'd0 - mr) : mr;
   end

   always_comb begin
      res      = 64'd0;
      div_zero = b_zero && is_div(op);
      unique case (1'b1)
         (op == MD_MULT):  res = prod_s;
         (op == MD_MULTU): res = prod_u;
         (op == MD_DIV):   res = {sr, sq};
         (op == MD_DIVU):  res = {ur, uq};
         default:          res = 64'd0;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Result is computed at start and committed when the latency counter expires.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] mdOut
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ?
                               MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   md_state_t     state_q;
   md_state_t     state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [31:0]   hi_q;
   logic [31:0]   hi_d;
   logic [31:0]   lo_q;
   logic [31:0]   lo_d;
   logic [63:0]   pend_q;
   logic [63:0]   pend_d;
   logic          pend_we_q;
   logic          pend_we_d;
   logic          accept;
   logic [63:0]   calc_res;
   logic          calc_dz;

   md_calc u_calc (
      .op       (mdOp),
      .a        (A),
      .b        (B),
      .res      (calc_res),
      .div_zero (calc_dz)
   );

   assign accept = start && !busy && (is_mul(mdOp) || is_div(mdOp));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_BUSY;
         S_BUSY: if (cnt_q == CNT_ONE) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == S_BUSY);
      mdOut = 32'd0;
      if (mdOp == MD_MFHI) mdOut = hi_q;
      else if (mdOp == MD_MFLO) mdOut = lo_q;
   end

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_d    = pend_q;
      pend_we_d = pend_we_q;
      if (accept) begin
         cnt_d     = is_mul(mdOp) ? MULT_N : DIV_N;
         pend_d    = calc_res;
         pend_we_d = !calc_dz;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
         // Commit on the same edge that drops busy
         if (cnt_q == CNT_ONE && pend_we_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
         end
      end else if (!start) begin
         if (mdOp == MD_MTHI) hi_d = A;
         if (mdOp == MD_MTLO) lo_d = A;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_q    <= 64'd0;
         pend_we_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_q    <= pend_d;
         pend_we_q <= pend_we_d;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected {HI,LO} queued at issue,
// popped and checked when busy falls.
module tb_e_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  mdOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] mdOut;

   int n_cmp;
   int n_bad;
   logic [63:0] sb_q[$];

   e_mdu dut (
      .clk   (clk),
      .reset (rst_n),
      .start (start),
      .mdOp  (mdOp),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO),
      .mdOut (mdOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      start = 1'b1;
      mdOp  = op;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      mdOp  = MD_NONE;
      A     = 32'd0;
      B     = 32'd0;
   endtask

   task automatic finish_op(input int exp_n, input int seen0,
                            input string tag);
      int seen;
      int guard;
      logic [63:0] e;
      seen  = seen0;
      guard = 0;
      while (busy === 1'b1 && guard < 40) begin
         seen++;
         guard++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(seen), 32'(exp_n));
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_hi"}, HI, e[63:32]);
         chk({tag, "_lo"}, LO, e[31:0]);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      mdOp  = MD_NONE;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mdout", mdOut, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
      issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
      finish_op(5, 0, "mult_neg");
      mdOp = MD_MFLO;
      #1 chk("mflo", mdOut, 32'hFFFFFFFA);
      mdOp = MD_MFHI;
      #1 chk("mfhi", mdOut, 32'hFFFFFFFF);

      // Issued in the first cycle after busy falls
      sb_q.push_back({32'h00000001, 32'hFFFFFFFE});
      issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
      finish_op(5, 0, "multu");

      sb_q.push_back({32'h40000000, 32'h00000000});
      issue(MD_MULT, 32'h80000000, 32'h80000000);
      finish_op(5, 0, "mult_min");

      sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
      finish_op(10, 0, "div_neg");

      sb_q.push_back({32'h00000001, 32'h7FFFFFFC});
      issue(MD_DIVU, 32'hFFFFFFF9, 32'd2);
      finish_op(10, 0, "divu");

      sb_q.push_back({32'h00000000, 32'h80000000});
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      finish_op(10, 0, "div_ovf");

      sb_q.push_back({32'h00000001, 32'hFFFFFFFD});
      issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
      finish_op(10, 0, "div_negdvs");

      mdOp = MD_MTHI;
      A    = 32'h11;
      @(negedge clk);
      mdOp = MD_MTLO;
      A    = 32'h22;
      @(negedge clk);
      mdOp = MD_NONE;
      A    = 32'd0;
      chk("mthi", HI, 32'h11);
      chk("mtlo", LO, 32'h22);

      sb_q.push_back({32'h11, 32'h22});
      issue(MD_DIV, 32'd1234, 32'd0);
      finish_op(10, 0, "div_zero");

      sb_q.push_back({32'h11, 32'h22});
      issue(MD_DIVU, 32'd99, 32'd0);
      finish_op(10, 0, "divu_zero");

      // start with a non-arith op is dropped, and MTHI needs start low
      issue(MD_MTHI, 32'hDEAD, 32'd0);
      chk("bad_op_busy", 32'(busy), 32'd0);
      chk("bad_op_hi", HI, 32'h11);

      // Second start in the 3rd busy cycle of a DIV
      sb_q.push_back({32'h2, 32'hE});
      issue(MD_DIV, 32'd100, 32'd7);
      chk("ign_b1", 32'(busy), 32'd1);
      @(negedge clk);
      chk("ign_b2", 32'(busy), 32'd1);
      @(negedge clk);
      chk("ign_b3", 32'(busy), 32'd1);
      issue(MD_MULT, 32'd5, 32'd5);
      finish_op(10, 3, "div_ignore");
      @(negedge clk);
      chk("ign_after_busy", 32'(busy), 32'd0);
      chk("ign_after_lo", LO, 32'hE);

      // Reset in the 4th busy cycle of a MULT
      issue(MD_MULT, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_hi", HI, 32'd0);
      chk("mid_rst_lo", LO, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_hi", HI, 32'd0);
      chk("post_rst_lo", LO, 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit owning the HI/LO registers. It accepts a one-cycle start pulse with an operation code and two 32-bit operands, and models a fixed multi-cycle latency by holding `busy` high. It returns `mfhi`/`mflo` data combinationally. Its `start` and `busy` lines feed the pipeline stall unit, which freezes IFU/D/E for every cycle either is high.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle pulse: E-stage instruction is mult/multu/div/divu.
- `mdOp`  in  4  operation code (package constants): NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `busy`  out  1  computation in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `mdOut`  out  32  mfhi/mflo read data.

## Operation
- Reset asserted (async): HI=0, LO=0, busy=0, counter=0, pending results=0.
- Start acceptance: `start`=1 with `busy`=0 and `mdOp` ∈ {MULT, MULTU, DIV, DIVU} → latch the op and operands, compute the pending {HI,LO} result, load counter with the op's cycle count, set busy.
- `start` while `busy`=1 is ignored.
- `start` with any other `mdOp` is ignored.
- MULT: {HI,LO} = signed 64-bit A*B.
- MULTU: {HI,LO} = unsigned 64-bit A*B.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, which carries the sign of the dividend.
- DIV overflow case: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (div or divu): HI/LO keep their previous values; busy timing is unchanged.
- MTHI/MTLO with `busy`=0 and `start`=0: HI (or LO) = A at the edge. Ignored while busy; the stall unit prevents this case.
- `mdOut` = HI when `mdOp`=MFHI, LO when MFLO, otherwise 0. Always reflects the current register value.
- No internal stall or flush input. The stall unit holds E stable, so `start` is never repeated for the same instruction.

## Timing
- Start accepted at edge t0 → busy=1 during cycles t0+1 … t0+N, where N = MULT_CYCLES or DIV_CYCLES.
- At edge t0+N: counter 1→0, busy falls, and HI/LO take the pending result in the same edge.
- HI/LO therefore become visible in cycle t0+N+1. This is also the first cycle in which a dependent mfhi/mflo can leave D.
- The stall unit sees `start` in cycle t0 and `busy` in cycles t0+1…t0+N, so the stall covers N+1 contiguous cycles.
- MTHI/MTLO write at the edge ending their E cycle. `mdOut` is combinational (zero latency).
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1). It decrements only while nonzero, so there is no wrap.
- Reset asserted mid-operation: the op is abandoned, busy=0 immediately, HI/LO=0. No result is written after reset releases.
- Simultaneous start and MTHI are impossible (a single `mdOp`). A start in the same cycle busy falls is accepted, because busy is already 0 in that cycle.

## Structure
- Shared package `mdu_pkg`:
  - `mdOp` encoding constants.
  - Default cycle counts.
  - Shared by the decoder, the stall unit's Tuse/Tnew logic, and this block.
- One natural sub-module `md_calc`: combinational 64-bit result generator for op/A/B, including the divide-by-zero flag.
- The sequential part (counter, busy, HI/LO, pending registers) lives in `e_mdu`.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO gives `mdOut`=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
- DIV by zero with HI=0x11, LO=0x22 preset via MTHI/MTLO → busy 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- Second `start` (MULT) pulsed in the 3rd busy cycle of a DIV → ignored; busy still falls after exactly 10 cycles with the DIV result.
- `reset` pulled low in the 4th busy cycle of a MULT → busy=0 and HI=LO=0 immediately; they stay 0 after release; no late write-back.
